// File: rtl/uart_tx.sv
// UART transmitter: pops one word from the TX FIFO and sends start, D_W data bits LSB first, stop.
// Build with UART_TX_PARITY_EN defined to insert an even-parity bit between the data bits and stop.
module uart_tx #(
  parameter int D_W     = 8,
  parameter int B_TICK  = 16,
  parameter int SB_TICK = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_en,
  input  logic [D_W-1:0] in_data,
  input  logic           ff_empty,
  output logic           ff_rd_en,
  output logic           tx_data,
  output logic           tx_busy
);

  // state  | meaning
  // IDLE   | line high, pop the FIFO as soon as it is non-empty
  // LOAD   | popped word is on in_data, capture it
  // START  | start bit (0) for B_TICK baud pulses
  // DATA   | data bits, LSB first, B_TICK pulses each
  // PARITY | even parity bit (UART_TX_PARITY_EN builds only)
  // STOP   | stop bit (1) for SB_TICK pulses
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif
  localparam logic [2:0] S_STOP   = 3'd5;

  localparam int TMAX   = (B_TICK > SB_TICK) ? B_TICK : SB_TICK;
  localparam int TICK_W = ($clog2(TMAX) > 4) ? $clog2(TMAX) : 4;
  localparam int BIT_W  = (D_W > 1) ? $clog2(D_W) : 1;

  localparam logic [TICK_W-1:0] B_LAST   = TICK_W'(B_TICK - 1);
  localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(D_W - 1);

  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q,  tick_d;
  logic [BIT_W-1:0]  bit_q,   bit_d;
  logic [D_W-1:0]    shreg_q, shreg_d;
  logic              tx_q,    tx_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q,   par_d;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (!ff_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        shreg_d = in_data;
        tick_d  = '0;
        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
        par_d   = ^in_data;
`endif
        state_d = S_START;
      end
      S_START: begin
        if (baud_en) begin
          if (tick_q == B_LAST) begin
            tick_d  = '0;
            state_d = S_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (baud_en) begin
          if (tick_q == B_LAST) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
`ifdef UART_TX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_en) begin
          if (tick_q == B_LAST) begin
            tick_d  = '0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (baud_en) begin
          if (tick_q == SB_LAST) begin
            tick_d  = '0;
            state_d = S_IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // line level follows the state being entered so tx_data is registered yet not lagging
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // pop is combinational so a back-to-back word is taken in the very IDLE clock
  assign ff_rd_en = (state_q == S_IDLE) && !ff_empty && !rst;
  assign tx_data  = tx_q;
  assign tx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a FIFO model plus a frame-as-segment-list reference predicts every clock.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;
  localparam int D_W     = 8;
  localparam int B_TICK  = 16;
  localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam int N_SEG = D_W + 3;
`else
  localparam int N_SEG = D_W + 2;
`endif
  localparam int BUDGET = 20000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           baud_en = 1'b0;
  logic [D_W-1:0] in_data = '0;
  logic           ff_empty = 1'b1;
  logic           ff_rd_en, tx_data, tx_busy;

  uart_tx #(.D_W(D_W), .B_TICK(B_TICK), .SB_TICK(SB_TICK)) dut (
    .clk(clk), .rst(rst), .baud_en(baud_en), .in_data(in_data),
    .ff_empty(ff_empty), .ff_rd_en(ff_rd_en), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int pushed = 0, dut_pops = 0, bcnt = 0;

  // reference: FIFO contents and the remaining line segments of the frame in flight
  logic [D_W-1:0] fifo[$];
  bit             seg_lvl[$];
  int             seg_len[$];
  bit             m_idle = 1'b1, m_load = 1'b0;
  int             m_left = 0;
  logic [D_W-1:0] m_byte = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_frame(input logic [D_W-1:0] d);
    seg_lvl.delete();
    seg_len.delete();
    seg_lvl.push_back(1'b0); seg_len.push_back(B_TICK);
    for (int i = 0; i < D_W; i++) begin
      seg_lvl.push_back(d[i]); seg_len.push_back(B_TICK);
    end
`ifdef UART_TX_PARITY_EN
    seg_lvl.push_back(^d); seg_len.push_back(B_TICK);
`endif
    seg_lvl.push_back(1'b1); seg_len.push_back(SB_TICK);
    m_left = seg_len[0];
  endtask

  function automatic bit exp_tx();
    if (m_idle || m_load) return 1'b1;
    return seg_lvl[0];
  endfunction

  function automatic bit baud(input int mode);
    bcnt++;
    case (mode)
      0:       return (bcnt % 4) == 0;
      1:       return $urandom_range(0, 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic [D_W-1:0] d);
    fifo.push_back(d);
    pushed++;
  endtask

  // one clock: drive inputs at negedge, check the pop, advance the model at posedge, check the line
  task automatic step(input bit r, input bit b);
    bit pop;
    @(negedge clk);
    in_data  = m_load ? m_byte : D_W'($urandom);
    rst      = r;
    baud_en  = b;
    ff_empty = (fifo.size() == 0);
    #1;
    pop = m_idle && !r && (fifo.size() != 0);
    chk("ff_rd_en", ff_rd_en, pop);
    if (ff_rd_en === 1'b1) dut_pops++;
    @(posedge clk);
    if (r) begin
      m_idle = 1'b1; m_load = 1'b0;
      seg_lvl.delete(); seg_len.delete();
    end else if (m_idle) begin
      if (pop) begin
        m_byte = fifo.pop_front();
        m_idle = 1'b0; m_load = 1'b1;
      end
    end else if (m_load) begin
      build_frame(m_byte);
      m_load = 1'b0;
    end else if (b) begin
      m_left--;
      if (m_left == 0) begin
        seg_lvl.delete(0); seg_len.delete(0);
        if (seg_lvl.size() == 0) m_idle = 1'b1;
        else m_left = seg_len[0];
      end
    end
    #1;
    chk("tx_data", tx_data, exp_tx());
    chk("tx_busy", tx_busy, !m_idle);
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) step(1'b0, baud(mode));
  endtask

  task automatic drain(input int mode);
    int n = 0;
    while (!(m_idle && fifo.size() == 0) && n < BUDGET) begin
      step(1'b0, baud(mode));
      n++;
    end
    chk("drain_timeout", n < BUDGET, 1);
    run(3, mode);
  endtask

  // advance until the frame in flight is in segment seg_idx with half its pulses left
  task automatic reach(input int seg_idx, input int mode);
    int n = 0;
    while (!(!m_idle && !m_load && seg_lvl.size() == N_SEG - seg_idx && m_left == B_TICK / 2)
           && n < BUDGET) begin
      step(1'b0, baud(mode));
      n++;
    end
    chk("reach_timeout", n < BUDGET, 1);
  endtask

  initial begin
    // reset with empty FIFO, then idle with nothing to send for 10 bit times
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    run(10 * B_TICK * 4, 0);

    // reset held with data waiting: no pop until it is released
    push(8'hA5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    drain(0);

    // single frame, then back-to-back pair
    push(8'h55);
    drain(0);
    push(8'h55);
    push(8'hDF);
    drain(0);

    // parity values of interest (plain frames in the default build)
    push(8'h07);
    drain(1);

    // baud_en held low in the middle of the start bit
    push(8'h3C);
    reach(0, 0);
    run(40, 2);
    chk("start_hold_tx", tx_data, 0);
    chk("start_hold_busy", tx_busy, 1);
    drain(0);

    // reset during data bit 3 aborts the frame; the next word goes out cleanly
    push(8'h96);
    push(8'h0F);
    reach(4, 0);
    step(1'b1, 1'b1);
    chk("abort_tx", tx_data, 1);
    chk("abort_busy", tx_busy, 0);
    drain(0);

    // random words, random burst sizes, irregular baud pulses
    for (int k = 0; k < 6; k++) begin
      int nb = $urandom_range(1, 2);
      for (int j = 0; j < nb; j++) push(D_W'($urandom));
      drain(1);
    end

    chk("pop_count", dut_pops, pushed);
    chk("fifo_left", fifo.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter D_W, default 8: data bits per frame.
REQ-002 Parameter B_TICK, default 16: baud_en pulses per data/start/parity bit.
REQ-003 Parameter SB_TICK, default 16: baud_en pulses for the stop bit.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 baud_en  input  1  one-clk pulse from baud_gen at B_TICK x baud rate.
REQ-007 in_data  input  D_W  TX FIFO data_out; valid the clock after ff_rd_en.
REQ-008 ff_empty  input  1  TX FIFO empty flag.
REQ-009 ff_rd_en  output  1  one-clk FIFO pop strobe.
REQ-010 tx_data  output  1  serial line; idle high.
REQ-011 tx_busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE with ff_empty=0: assert ff_rd_en for exactly one clk and go to LOAD; ff_rd_en never asserted while ff_empty=1.
REQ-014 LOAD: capture in_data into the shift register, clear tick and bit counters, go to START; total 2 clks from pop to START.
REQ-015 tx_data SHALL be registered: 1 in IDLE/LOAD/STOP, 0 in START, shift-register bit 0 in DATA, parity bit in PARITY.
REQ-016 A 4-bit-or-wider tick counter SHALL increment only on baud_en; baud_en in IDLE/LOAD is ignored.
REQ-017 START/DATA/PARITY: on the baud_en pulse with tick = B_TICK-1, reset tick to 0 and advance; each bit lasts exactly B_TICK baud_en pulses.
REQ-018 DATA: on each bit end, shift right (LSB first) and increment bit counter; after bit D_W-1 go to PARITY (macro) or STOP.
REQ-019 STOP: on baud_en with tick = SB_TICK-1 go to IDLE.
REQ-020 Back-to-back: if ff_empty=0 on return to IDLE, the next pop occurs in that IDLE clk; inter-frame idle is 2 clks (IDLE+LOAD).
REQ-021 in_data changes outside LOAD SHALL not affect an in-flight frame.
REQ-022 Counters SHALL wrap to 0 at their terminal values, never overflow.
REQ-023 tx_busy SHALL be low only in IDLE.

Reset
REQ-024 On rst=1 at a clk edge: state IDLE, tx_data=1, ff_rd_en=0, tx_busy=0, counters and shift register 0.
REQ-025 Reset mid-frame SHALL abort the frame, drive tx_data=1 from the next clk, and not pop the FIFO during reset.
REQ-026 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: after DATA, PARITY state sends even parity (XOR of the D_W data bits) for B_TICK pulses, then STOP.
REQ-028 Macro undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Verification
REQ-029 FIFO holds 0x55, B_TICK=16 -> tx_data = 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each bit 16 baud_en pulses; one ff_rd_en pulse.
REQ-030 FIFO holds 0x55, 0xDF back-to-back -> two frames; second start bit 2 clks after the first stop bit ends; two ff_rd_en pulses total.
REQ-031 UART_TX_PARITY_EN, data 0x07 -> parity bit 1 between bit 7 and stop; data 0x55 -> parity bit 0.
REQ-032 rst pulsed during DATA bit 3 -> tx_data=1 and tx_busy=0 on the next clk; the next frame starts cleanly from IDLE.
REQ-033 ff_empty=1 held for 10 bit times -> ff_rd_en stays 0, tx_data stays 1, tx_busy stays 0.
REQ-034 baud_en held low mid-START -> tx_data stays 0 and the state does not advance.
